// File: rtl/kypd_scanner.sv
// Pmod KYPD 4x4 keypad scanner: drives one column low at a time, samples the
// synchronized rows, debounces whole-keypad scans and emits press/release events.
module kypd_scanner #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_100,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_press,
    output logic       key_release
);
    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(SCAN_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    logic [1:0]    col_idx_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    hit_cnt_q,   hit_cnt_d;
    logic [3:0]    cand_q,      cand_d;
    logic          prev_valid_q, prev_valid_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [SW-1:0] stable_q,    stable_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic          key_down_q,  key_down_d;
    logic          key_press_q, key_press_d;
    logic          key_release_q, key_release_d;

    logic [3:0] row_hit;
    logic [2:0] n_low;
    logic [1:0] hit_row;
    logic [2:0] hit_sum;
    logic [1:0] hit_acc;
    logic [3:0] cand_acc;
    logic       sample;
    logic       end_scan;
    logic       scan_valid;
    logic [3:0] scan_code;
    logic       same_result;
    logic       update;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_line
            assign col_out[gi] = (col_idx_q != 2'(gi));
            assign row_hit[gi] = ~row_sync_q[gi];
        end
    endgenerate

    always_comb begin
        n_low   = '0;
        hit_row = '0;
        for (int i = 3; i >= 0; i--) begin
            if (row_hit[i]) begin
                hit_row = 2'(i);
            end
            n_low = n_low + {2'b00, row_hit[i]};
        end
    end

    // Accumulated view of the scan including the column being sampled now.
    assign hit_sum    = {1'b0, hit_cnt_q} + n_low;
    assign hit_acc    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign cand_acc   = (n_low != 3'd0) ? key_map(hit_row, col_idx_q) : cand_q;
    assign sample     = (dwell_q == LAST_DWELL);
    assign end_scan   = sample && (col_idx_q == 2'd3);
    assign scan_valid = (hit_acc == 2'd1);
    assign scan_code  = scan_valid ? cand_acc : 4'h0;
    assign same_result = (scan_valid == prev_valid_q) && (scan_code == prev_code_q);

    always_comb begin
        hit_cnt_d    = hit_cnt_q;
        cand_d       = cand_q;
        prev_valid_d = prev_valid_q;
        prev_code_d  = prev_code_q;
        stable_d     = stable_q;
        if (sample) begin
            hit_cnt_d = end_scan ? 2'd0 : hit_acc;
            cand_d    = end_scan ? 4'h0 : cand_acc;
        end
        if (end_scan) begin
            prev_valid_d = scan_valid;
            prev_code_d  = scan_code;
            if (!same_result) begin
                stable_d = SW'(1);
            end else if (stable_q != STABLE_MAX) begin
                stable_d = stable_q + SW'(1);
            end
        end
    end

    assign update = end_scan && (stable_d == STABLE_MAX);

    always_comb begin
        key_code_d    = key_code_q;
        key_down_d    = key_down_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        if (update) begin
            if (scan_valid) begin
                // A different key replacing a held one releases the old and presses the new.
                if (!key_down_q || (scan_code != key_code_q)) begin
                    key_press_d   = 1'b1;
                    key_release_d = key_down_q;
                end
                key_code_d = scan_code;
                key_down_d = 1'b1;
            end else if (key_down_q) begin
                key_down_d    = 1'b0;
                key_release_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            row_meta_q    <= 4'b1111;
            row_sync_q    <= 4'b1111;
            col_idx_q     <= 2'd0;
            dwell_q       <= '0;
            hit_cnt_q     <= 2'd0;
            cand_q        <= 4'h0;
            prev_valid_q  <= 1'b0;
            prev_code_q   <= 4'h0;
            stable_q      <= '0;
            key_code_q    <= 4'h0;
            key_down_q    <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            row_meta_q    <= row_in;
            row_sync_q    <= row_meta_q;
            if (sample) begin
                dwell_q   <= '0;
                col_idx_q <= col_idx_q + 2'd1;
            end else begin
                dwell_q   <= dwell_q + DW'(1);
            end
            hit_cnt_q     <= hit_cnt_d;
            cand_q        <= cand_d;
            prev_valid_q  <= prev_valid_d;
            prev_code_q   <= prev_code_d;
            stable_q      <= stable_d;
            key_code_q    <= key_code_d;
            key_down_q    <= key_down_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_down    = key_down_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;

endmodule

// File: tb/tb_kypd_scanner.sv
// Bench for kypd_scanner: a keypad model drives rows from the column strobe, and a
// scan-level reference model (history of whole-scan results) predicts every event.
module tb_kypd_scanner;
    localparam int SCAN   = 8;
    localparam int DEB    = 3;
    localparam int PERIOD = 4 * SCAN;

    logic       clk_100 = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_down;
    logic       key_press;
    logic       key_release;

    logic [15:0] key_mask = '0;
    int n_chk  = 0;
    int n_pass = 0;
    int scan_no = 0;

    // Legend indexed by row*4 + col.
    logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};

    int         hist[$];
    int         m_state = -1;
    logic [3:0] m_code  = 4'h0;
    logic       exp_press = 1'b0;
    logic       exp_release = 1'b0;

    logic       obs_press, obs_release, obs_down;
    logic [3:0] obs_code;
    int         obs_stray, obs_col_bad, obs_lvl;

    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] K2 = 16'h0002;
    localparam logic [15:0] K3 = 16'h0004;
    localparam logic [15:0] KA = 16'h0008;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K7 = 16'h0100;
    localparam logic [15:0] K9 = 16'h0400;

    kypd_scanner #(
        .SCAN_CYCLES   (SCAN),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk_100    (clk_100),
        .reset      (reset),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_code   (key_code),
        .key_down   (key_down),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk_100 = ~clk_100;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    function automatic int scan_result(input logic [15:0] mask);
        if ($countones(mask) != 1) return -1;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) return int'(legend[i]);
        end
        return -1;
    endfunction

    // Debounced state changes when the last DEB whole-scan results agree and differ from it.
    task automatic model_scan(input logic [15:0] mask);
        int res;
        bit agree;
        res = scan_result(mask);
        hist.push_back(res);
        if (hist.size() > DEB) void'(hist.pop_front());
        exp_press   = 1'b0;
        exp_release = 1'b0;
        agree = (hist.size() == DEB);
        foreach (hist[i]) begin
            if (hist[i] != res) agree = 1'b0;
        end
        if (agree && res != m_state) begin
            exp_press   = (res != -1);
            exp_release = (m_state != -1);
            m_state     = res;
            if (res != -1) m_code = 4'(res);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_state     = -1;
        m_code      = 4'h0;
        exp_press   = 1'b0;
        exp_release = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_100);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Holds one keypad mask for a whole scan, starting at a scan boundary.
    task automatic run_scan(input logic [15:0] mask);
        logic [3:0] one_hot;
        logic [3:0] exp_col;
        logic [3:0] code0;
        logic       down0;
        key_mask    = mask;
        obs_stray   = 0;
        obs_col_bad = 0;
        obs_lvl     = 0;
        code0 = key_code;
        down0 = key_down;
        for (int j = 0; j < PERIOD; j++) begin
            one_hot = 4'b0001;
            one_hot = one_hot << (j / SCAN);
            exp_col = ~one_hot;
            if (col_out !== exp_col) obs_col_bad++;
            if (j > 0) begin
                if (key_press !== 1'b0 || key_release !== 1'b0) obs_stray++;
                if (key_code !== code0 || key_down !== down0) obs_lvl++;
            end
            @(posedge clk_100);
            #1;
        end
        obs_press   = key_press;
        obs_release = key_release;
        obs_code    = key_code;
        obs_down    = key_down;
        model_scan(mask);
        scan_no++;
        $display("scan %0d mask=%h press=%b release=%b code=%h down=%b",
                 scan_no, mask, obs_press, obs_release, obs_code, obs_down);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({col_out, key_code, key_down, key_press, key_release} !== {4'b1110, 4'h0, 3'b000})
            $display("FAIL reset_state: got col=%b code=%h down=%b press=%b release=%b, want col=1110 code=0 down=0 press=0 release=0",
                     col_out, key_code, key_down, key_press, key_release);
        else n_pass++;
    endtask

    task automatic test_idle_scan();
        for (int s = 0; s < 4; s++) begin
            run_scan(16'h0000);
            n_chk++;
            if ({obs_press, obs_release, obs_code, obs_down} !== {exp_press, exp_release, m_code, (m_state != -1)}
                || obs_stray != 0 || obs_col_bad != 0 || obs_lvl != 0)
                $display("FAIL idle_scan %0d: got press=%b release=%b code=%h down=%b stray=%0d col_bad=%0d glitch=%0d, want press=%b release=%b code=%h down=%b none",
                         s, obs_press, obs_release, obs_code, obs_down, obs_stray, obs_col_bad, obs_lvl,
                         exp_press, exp_release, m_code, (m_state != -1));
            else n_pass++;
        end
    endtask

    task automatic test_press_release();
        logic [15:0] plan[$];
        for (int s = 0; s < 13; s++) plan.push_back(K5);
        for (int s = 0; s < 5; s++)  plan.push_back(16'h0000);
        foreach (plan[s]) begin
            run_scan(plan[s]);
            n_chk++;
            if ({obs_press, obs_release, obs_code, obs_down} !== {exp_press, exp_release, m_code, (m_state != -1)}
                || obs_stray != 0 || obs_col_bad != 0 || obs_lvl != 0)
                $display("FAIL press_release %0d: got press=%b release=%b code=%h down=%b stray=%0d col_bad=%0d glitch=%0d, want press=%b release=%b code=%h down=%b none",
                         s, obs_press, obs_release, obs_code, obs_down, obs_stray, obs_col_bad, obs_lvl,
                         exp_press, exp_release, m_code, (m_state != -1));
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [15:0] plan[$];
        for (int s = 0; s < 4; s++) begin
            plan.push_back(KA);
            plan.push_back(KA);
            plan.push_back(16'h0000);
        end
        foreach (plan[s]) begin
            run_scan(plan[s]);
            n_chk++;
            if ({obs_press, obs_release, obs_code, obs_down} !== {exp_press, exp_release, m_code, (m_state != -1)}
                || obs_stray != 0 || obs_col_bad != 0 || obs_lvl != 0)
                $display("FAIL bounce %0d: got press=%b release=%b code=%h down=%b stray=%0d col_bad=%0d glitch=%0d, want press=%b release=%b code=%h down=%b none",
                         s, obs_press, obs_release, obs_code, obs_down, obs_stray, obs_col_bad, obs_lvl,
                         exp_press, exp_release, m_code, (m_state != -1));
            else n_pass++;
        end
    endtask

    task automatic test_key_switch();
        logic [15:0] plan[$];
        for (int s = 0; s < 4; s++) plan.push_back(K7);
        for (int s = 0; s < 4; s++) plan.push_back(K9);
        for (int s = 0; s < 4; s++) plan.push_back(16'h0000);
        foreach (plan[s]) begin
            run_scan(plan[s]);
            n_chk++;
            if ({obs_press, obs_release, obs_code, obs_down} !== {exp_press, exp_release, m_code, (m_state != -1)}
                || obs_stray != 0 || obs_col_bad != 0 || obs_lvl != 0)
                $display("FAIL key_switch %0d: got press=%b release=%b code=%h down=%b stray=%0d col_bad=%0d glitch=%0d, want press=%b release=%b code=%h down=%b none",
                         s, obs_press, obs_release, obs_code, obs_down, obs_stray, obs_col_bad, obs_lvl,
                         exp_press, exp_release, m_code, (m_state != -1));
            else n_pass++;
        end
    endtask

    task automatic test_multi_key();
        logic [15:0] plan[$];
        for (int s = 0; s < 4; s++) plan.push_back(K1);
        for (int s = 0; s < 4; s++) plan.push_back(K1 | K2);
        for (int s = 0; s < 4; s++) plan.push_back(K1);
        for (int s = 0; s < 4; s++) plan.push_back(16'h0000);
        foreach (plan[s]) begin
            run_scan(plan[s]);
            n_chk++;
            if ({obs_press, obs_release, obs_code, obs_down} !== {exp_press, exp_release, m_code, (m_state != -1)}
                || obs_stray != 0 || obs_col_bad != 0 || obs_lvl != 0)
                $display("FAIL multi_key %0d: got press=%b release=%b code=%h down=%b stray=%0d col_bad=%0d glitch=%0d, want press=%b release=%b code=%h down=%b none",
                         s, obs_press, obs_release, obs_code, obs_down, obs_stray, obs_col_bad, obs_lvl,
                         exp_press, exp_release, m_code, (m_state != -1));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_press();
        for (int s = 0; s < 4; s++) run_scan(K3);
        n_chk++;
        if ({key_code, key_down} !== 5'b0011_1)
            $display("FAIL pre_reset_held: got code=%h down=%b, want code=3 down=1", key_code, key_down);
        else n_pass++;
        for (int j = 0; j < 13; j++) begin
            @(posedge clk_100);
            #1;
        end
        do_reset();
        n_chk++;
        if ({col_out, key_code, key_down, key_press, key_release} !== {4'b1110, 4'h0, 3'b000})
            $display("FAIL reset_mid_press: got col=%b code=%h down=%b press=%b release=%b, want col=1110 code=0 down=0 press=0 release=0",
                     col_out, key_code, key_down, key_press, key_release);
        else n_pass++;
        for (int s = 0; s < 5; s++) begin
            run_scan(s < 4 ? K3 : 16'h0000);
            n_chk++;
            if ({obs_press, obs_release, obs_code, obs_down} !== {exp_press, exp_release, m_code, (m_state != -1)}
                || obs_stray != 0 || obs_col_bad != 0 || obs_lvl != 0)
                $display("FAIL redetect %0d: got press=%b release=%b code=%h down=%b stray=%0d col_bad=%0d glitch=%0d, want press=%b release=%b code=%h down=%b none",
                         s, obs_press, obs_release, obs_code, obs_down, obs_stray, obs_col_bad, obs_lvl,
                         exp_press, exp_release, m_code, (m_state != -1));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [15:0] bit_a, bit_b, mask;
        int kind, a, b, hold;
        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 3);
            a     = $urandom_range(0, 15);
            b     = (a + $urandom_range(1, 15)) % 16;
            bit_a = 16'h0001;
            bit_b = 16'h0001;
            bit_a = bit_a << a;
            bit_b = bit_b << b;
            mask  = (kind == 0) ? 16'h0000 : (kind == 3) ? (bit_a | bit_b) : bit_a;
            hold  = $urandom_range(1, 5);
            for (int s = 0; s < hold; s++) begin
                run_scan(mask);
                n_chk++;
                if ({obs_press, obs_release, obs_code, obs_down} !== {exp_press, exp_release, m_code, (m_state != -1)}
                    || obs_stray != 0 || obs_col_bad != 0 || obs_lvl != 0)
                    $display("FAIL random %0d.%0d mask=%h: got press=%b release=%b code=%h down=%b stray=%0d col_bad=%0d glitch=%0d, want press=%b release=%b code=%h down=%b none",
                             t, s, mask, obs_press, obs_release, obs_code, obs_down, obs_stray, obs_col_bad, obs_lvl,
                             exp_press, exp_release, m_code, (m_state != -1));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_bounce();
        test_key_switch();
        test_multi_key();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
